// File: rtl/spi_wb_pkg.sv
// Shared definitions for the SPI core's 8-bit Wishbone register map and
// the byte master FSM.
package spi_wb_pkg;

   localparam logic [2:0] ADR_SPCR = 3'd0;
   localparam logic [2:0] ADR_SPSR = 3'd1;
   localparam logic [2:0] ADR_SPDR = 3'd2;
   localparam logic [2:0] ADR_SPER = 3'd3;

   localparam int SPSR_SPIF    = 7;
   localparam int SPSR_WCOL    = 6;
   localparam int SPSR_WFFULL  = 3;
   localparam int SPSR_WFEMPTY = 2;
   localparam int SPSR_RFFULL  = 1;
   localparam int SPSR_RFEMPTY = 0;

   typedef enum logic [2:0] {
      INIT_CR,
      INIT_ER,
      IDLE,
      WR_DR,
      RD_SR,
      RD_DR,
      RSP
   } state_t;

   typedef struct packed {
      logic       we;
      logic [2:0] adr;
      logic [7:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/wb_single_access.sv
// One Wishbone classic read or write with an ack timeout; reports a one-cycle
// done or timeout pulse plus the read data.
module wb_single_access
   import spi_wb_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start,
   input  wb_req_t    req,
   output logic       done,
   output logic       timeout,
   output logic [7:0] rdata,
   output logic       cyc_o,
   output logic       stb_o,
   output logic [2:0] adr_o,
   output logic       we_o,
   output logic [7:0] dat_o,
   input  logic [7:0] dat_i,
   input  logic       ack_i
);

   localparam int CW = $clog2(ACK_TIMEOUT);

   logic [CW-1:0] wait_cnt;

   // start is only honoured with the bus idle, so every access ends with at
   // least one cyc_o=0 cycle before the next one can begin.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_o    <= 1'b0;
         stb_o    <= 1'b0;
         we_o     <= 1'b0;
         adr_o    <= '0;
         dat_o    <= '0;
         rdata    <= '0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         if (!cyc_o) begin
            if (start) begin
               cyc_o    <= 1'b1;
               stb_o    <= 1'b1;
               we_o     <= req.we;
               adr_o    <= req.adr;
               dat_o    <= req.we ? req.wdata : 8'h00;
               wait_cnt <= '0;
            end
         end else if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            done  <= 1'b1;
            if (!we_o) rdata <= dat_i;
         end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            timeout <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_wb_byte_master.sv
// Programs the SPI core after reset, then turns each request byte into an
// SPDR write, SPSR polling and an SPDR read, returning the received byte.
module spi_wb_byte_master
   import spi_wb_pkg::*;
#(
   parameter logic [7:0] SPCR_INIT   = 8'h50,
   parameter logic [7:0] SPER_INIT   = 8'h00,
   parameter int         ACK_TIMEOUT = 16,
   parameter int         POLL_LIMIT  = 1024
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       err_o,
   output logic       init_done_o,
   output logic       cyc_o,
   output logic       stb_o,
   output logic [2:0] adr_o,
   output logic       we_o,
   output logic [7:0] dat_o,
   input  logic [7:0] dat_i,
   input  logic       ack_i
);

   state_t      state;
   logic        issued;
   logic [15:0] poll_cnt;
   logic [7:0]  tx_byte;
   wb_req_t     wb_req;
   logic        access;
   logic        repoll;
   logic        start;
   logic        done;
   logic        timeout;
   logic [7:0]  rdata;

   always_comb begin
      wb_req = '0;
      access = 1'b0;
      case (state)
         INIT_CR: begin access = 1'b1; wb_req = '{1'b1, ADR_SPCR, SPCR_INIT}; end
         INIT_ER: begin access = 1'b1; wb_req = '{1'b1, ADR_SPER, SPER_INIT}; end
         WR_DR:   begin access = 1'b1; wb_req = '{1'b1, ADR_SPDR, tx_byte};   end
         RD_SR:   begin access = 1'b1; wb_req = '{1'b0, ADR_SPSR, 8'h00};     end
         RD_DR:   begin access = 1'b1; wb_req = '{1'b0, ADR_SPDR, 8'h00};     end
         default: ;
      endcase
   end

   // A repeat poll is launched straight from the done cycle so each extra
   // SPSR read costs only the access plus its mandatory idle cycle.
   assign repoll = (state == RD_SR) && done && rdata[SPSR_RFEMPTY] &&
                   (poll_cnt != 16'(POLL_LIMIT - 1));
   assign start  = access && (!issued || repoll);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= INIT_CR;
         issued      <= 1'b0;
         poll_cnt    <= '0;
         tx_byte     <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         err_o       <= 1'b0;
         init_done_o <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (start) issued <= 1'b1;
         if (timeout) begin
            err_o     <= 1'b1;
            issued    <= 1'b0;
            state     <= init_done_o ? IDLE : INIT_CR;
            req_ready <= init_done_o;
         end else begin
            case (state)
               INIT_CR: if (done) begin
                  state  <= INIT_ER;
                  issued <= 1'b0;
               end
               INIT_ER: if (done) begin
                  state       <= IDLE;
                  issued      <= 1'b0;
                  init_done_o <= 1'b1;
                  req_ready   <= 1'b1;
               end
               IDLE: if (req_valid && req_ready) begin
                  tx_byte   <= req_data;
                  req_ready <= 1'b0;
                  state     <= WR_DR;
               end
               WR_DR: if (done) begin
                  state    <= RD_SR;
                  issued   <= 1'b0;
                  poll_cnt <= '0;
               end
               RD_SR: if (done) begin
                  if (!rdata[SPSR_RFEMPTY]) begin
                     state  <= RD_DR;
                     issued <= 1'b0;
                  end else if (repoll) begin
                     poll_cnt <= poll_cnt + 1'b1;
                  end else begin
                     err_o     <= 1'b1;
                     state     <= IDLE;
                     issued    <= 1'b0;
                     req_ready <= 1'b1;
                  end
               end
               RD_DR: if (done) begin
                  rsp_data  <= rdata;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
                  issued    <= 1'b0;
               end
               RSP: if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= INIT_CR;
            endcase
         end
      end
   end

   wb_single_access #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_acc (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (start),
      .req     (wb_req),
      .done    (done),
      .timeout (timeout),
      .rdata   (rdata),
      .cyc_o   (cyc_o),
      .stb_o   (stb_o),
      .adr_o   (adr_o),
      .we_o    (we_o),
      .dat_o   (dat_o),
      .dat_i   (dat_i),
      .ack_i   (ack_i)
   );

endmodule
